uart_xcvr: RTL and testbench

Parametrised full-duplex UART transceiver; next generation of the fixed 8N1 UART top. Adds a configurable data width, parity, and stop-bit count. Uses a 16x-oversampled receiver with majority voting and valid/ready handshakes on both byte interfaces. RX error flags report framing, parity and overrun conditions. Sits between the board-level rxd/txd pins and on-chip byte producers and consumers.

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_xcvr_if.sv | 27 ++
 rtl/uart_os_tick.sv | 35 +++
 rtl/uart_xcvr.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the uart_xcvr transceiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Parity selection
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Oversampling: one bit period is OVS ticks; majority taken over three mid-bit ticks
    localparam int OVS       = 16;
    localparam int SAMPLE_LO = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI = 9;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Clock cycles per oversample tick, rounded to nearest, never below 1
    function automatic int calc_div(input int clk_freq, input int baud);
        int d;
        d = (clk_freq + (baud * OVS) / 2) / (baud * OVS);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

    // Expected parity bit for a payload; narrower payloads are zero-padded,
    // which leaves the XOR unchanged
    function automatic logic par_bit(input logic [7:0] d, input int parity);
        return (^d) ^ (parity == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
// Byte-side handshake bundle of the UART transceiver (TX producer + RX consumer).
// Latency: n/a (wires only).
// Backpressure: tx_valid/tx_ready and rx_valid/rx_ready handshakes.
// master: on-chip producer/consumer; slave: the transceiver.
interface uart_xcvr_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_os_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
// Latency: first tick DIV cycles after reset release (every cycle when DIV=1).
// Backpressure: none; always runs.
// Ports: sys_clk, rst (sync, active-high), tick (out).
module uart_os_tick #(
    parameter int DIV = 1
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART with configurable width/parity/stop bits, 16x oversampled RX.
// Latency: TX start bit begins on the first tick after accept; rx_valid is set on the stop-bit sample edge.
// Backpressure: tx_ready low while a frame is in flight; an unconsumed rx byte makes the next frame drop with rx_overrun.
// Ports: sys_clk, rst (sync, active-high), bus (byte handshakes), txd (serial out), rxd (async serial in).
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       sys_clk,
    input  logic       rst,
    uart_xcvr_if.slave bus,
    output logic       txd,
    input  logic       rxd
);
    localparam int         DIV        = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] TICK_LAST  = 4'(OVS - 1);
    localparam logic [3:0] TICK_PRE   = 4'(OVS - 2);
    localparam logic [3:0] S_LO       = 4'(SAMPLE_LO);
    localparam logic [3:0] S_MID      = 4'(SAMPLE_MID);
    localparam logic [3:0] S_HI       = 4'(SAMPLE_HI);
    localparam logic [2:0] BIT_LAST   = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST  = 1'(STOP_BITS - 1);
    localparam bit         HAS_PAR    = (PARITY != PAR_NONE);

    logic tick;

    uart_os_tick #(.DIV(DIV)) u_os_tick (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [3:0]           tx_tick_q, tx_tick_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_ready_int;

    assign tx_ready_int = (tx_state_q == TX_IDLE) && !rst;

    // The edge that changes txd counts as tick 0 of the new bit, so each
    // bit holds for exactly OVS ticks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (bus.tx_valid && tx_ready_int) begin
                    tx_shift_d = bus.tx_data;
                    tx_par_d   = par_bit(8'(bus.tx_data), PARITY);
                    tx_tick_d  = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    // txd still high here means the start bit has not begun yet
                    if (txd_q) begin
                        txd_d     = 1'b0;
                        tx_tick_d = '0;
                    end else if (tx_tick_q == TICK_LAST) begin
                        txd_d      = tx_shift_q[0];
                        tx_tick_d  = '0;
                        tx_bit_d   = '0;
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_tick_q == TICK_LAST) begin
                        tx_tick_d = '0;
                        if (tx_bit_q == BIT_LAST) begin
                            if (HAS_PAR) begin
                                txd_d      = tx_par_q;
                                tx_state_d = TX_PARITY;
                            end else begin
                                txd_d      = 1'b1;
                                tx_stop_d  = 1'b0;
                                tx_state_d = TX_STOP;
                            end
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = tx_shift_q >> 1;
                            txd_d      = tx_shift_q[1];
                        end
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    if (tx_tick_q == TICK_LAST) begin
                        txd_d      = 1'b1;
                        tx_tick_d  = '0;
                        tx_stop_d  = 1'b0;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    // Leave on the 16th tick of the last stop bit so a waiting
                    // byte can start without an extra idle bit.
                    if ((tx_stop_q == STOP_LAST) && (tx_tick_q == TICK_PRE)) begin
                        tx_state_d = TX_IDLE;
                    end else if (tx_tick_q == TICK_LAST) begin
                        tx_tick_d = '0;
                        tx_stop_d = 1'b1;
                    end else begin
                        tx_tick_d = tx_tick_q + 4'd1;
                    end
                end
            end
            default: begin
                txd_d      = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    assign txd          = txd_q;
    assign bus.tx_ready = tx_ready_int;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                 rxd_meta_q, rxd_meta_d;
    logic                 rxd_sync_q, rxd_sync_d;
    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_tick_q, rx_tick_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [1:0]           rx_samp_q, rx_samp_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_frm_perr_q, rx_frm_perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_maj;
    logic                 rx_done;
    logic                 rx_mid;
    logic                 rx_end;

    // Majority of the samples at ticks 7 and 8 with the live sample at tick 9
    assign rx_maj = (rx_samp_q[0] & rx_samp_q[1]) |
                    (rx_samp_q[0] & rxd_sync_q)   |
                    (rx_samp_q[1] & rxd_sync_q);
    assign rx_mid = tick && (rx_tick_q == S_HI);
    assign rx_end = tick && (rx_tick_q == TICK_LAST);

    always_comb begin
        rxd_meta_d    = rxd;
        rxd_sync_d    = rxd_meta_q;
        rx_state_d    = rx_state_q;
        rx_tick_d     = rx_tick_q;
        rx_bit_d      = rx_bit_q;
        rx_samp_d     = rx_samp_q;
        rx_shift_d    = rx_shift_q;
        rx_frm_perr_d = rx_frm_perr_q;
        rx_done       = 1'b0;

        if (rx_state_q != RX_IDLE && tick) begin
            rx_tick_d = rx_tick_q + 4'd1;
            if (rx_tick_q == S_LO) begin
                rx_samp_d[0] = rxd_sync_q;
            end
            if (rx_tick_q == S_MID) begin
                rx_samp_d[1] = rxd_sync_q;
            end
        end

        unique case (rx_state_q)
            RX_IDLE: begin
                rx_tick_d = '0;
                if (!rxd_sync_q) begin
                    rx_frm_perr_d = 1'b0;
                    rx_state_d    = RX_START;
                end
            end
            RX_START: begin
                if (rx_mid && rx_maj) begin
                    rx_state_d = RX_IDLE;       // glitch, not a start bit
                end else if (rx_end) begin
                    rx_bit_d   = '0;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
                end
                if (rx_end) begin
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_mid) begin
                    rx_frm_perr_d = rx_maj ^ par_bit(8'(rx_shift_q), PARITY);
                end
                if (rx_end) begin
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Only the first stop bit is checked; returning to IDLE here
                // lets the next start edge be caught early.
                if (rx_mid) begin
                    rx_done    = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Output holding register: consume, load, or drop-with-overrun
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        rx_ovr_d   = 1'b0;
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (rx_done) begin
            if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = rx_shift_q;
                rx_ferr_d  = !rx_maj;
                rx_perr_d  = rx_frm_perr_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rxd_meta_q    <= 1'b1;
            rxd_sync_q    <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_tick_q     <= '0;
            rx_bit_q      <= '0;
            rx_samp_q     <= '0;
            rx_shift_q    <= '0;
            rx_frm_perr_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ovr_q      <= 1'b0;
        end else begin
            rxd_meta_q    <= rxd_meta_d;
            rxd_sync_q    <= rxd_sync_d;
            rx_state_q    <= rx_state_d;
            rx_tick_q     <= rx_tick_d;
            rx_bit_q      <= rx_bit_d;
            rx_samp_q     <= rx_samp_d;
            rx_shift_q    <= rx_shift_d;
            rx_frm_perr_q <= rx_frm_perr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_perr_q     <= rx_perr_d;
            rx_ovr_q      <= rx_ovr_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: three instances (8N1, 8E2 looped back, 8O1),
// one bit period = 16 clocks. Inputs change and outputs are sampled on negedge.
module tb_uart_xcvr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic txd8, txde, txdo;
    logic rxd8, rxdo;

    uart_xcvr_if #(.DATA_BITS(8)) if8 ();
    uart_xcvr_if #(.DATA_BITS(8)) ife ();
    uart_xcvr_if #(.DATA_BITS(8)) ifo ();

    uart_xcvr #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.sys_clk(clk), .rst(rst), .bus(if8), .txd(txd8), .rxd(rxd8));
    uart_xcvr #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2))
        u_8e2 (.sys_clk(clk), .rst(rst), .bus(ife), .txd(txde), .rxd(txde));
    uart_xcvr #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_8o1 (.sys_clk(clk), .rst(rst), .bus(ifo), .txd(txdo), .rxd(rxdo));

    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt  = 0;

    always @(negedge clk) begin
        if (if8.rx_overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one bit on the 8N1 (sel_odd=0) or 8O1 (sel_odd=1) receiver
    task automatic rx_bit(input bit sel_odd, input logic b);
        if (sel_odd) rxdo = b; else rxd8 = b;
        cycles(16);
    endtask

    task automatic rx_frame(input bit sel_odd, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
        rx_bit(sel_odd, 1'b0);
        for (int i = 0; i < 8; i++) rx_bit(sel_odd, d[i]);
        if (has_par) rx_bit(sel_odd, par);
        rx_bit(sel_odd, stop);
        if (sel_odd) rxdo = 1'b1; else rxd8 = 1'b1;
    endtask

    logic [9:0]  f_a5;
    logic [11:0] f_3c;
    int          low_cnt;
    int          ovr_base;

    initial begin
        rst = 1'b1;
        rxd8 = 1'b1; rxdo = 1'b1;
        if8.tx_valid = 1'b0; if8.tx_data = '0; if8.rx_ready = 1'b0;
        ife.tx_valid = 1'b0; ife.tx_data = '0; ife.rx_ready = 1'b0;
        ifo.tx_valid = 1'b0; ifo.tx_data = '0; ifo.rx_ready = 1'b0;
        f_a5 = {1'b1, 8'hA5, 1'b0};
        // 0x3C has four ones: even parity bit 0, then two stop bits
        f_3c = {2'b11, 1'b0, 8'h3C, 1'b0};

        // ---- reset state ----
        cycles(3);
        check("rst_tx_ready", if8.tx_ready, 0);
        check("rst_txd", txd8, 1);
        rst = 1'b0;
        cycles(2);
        check("post_rst_tx_ready", if8.tx_ready, 1);
        check("rst_rx_valid", if8.rx_valid, 0);
        check("rst_rx_data", if8.rx_data, 0);
        check("rst_frame_err", if8.rx_frame_err, 0);
        check("rst_parity_err", if8.rx_parity_err, 0);

        // ---- TX 8N1 0xA5 ----
        if8.tx_data = 8'hA5; if8.tx_valid = 1'b1;
        @(negedge clk);
        if8.tx_valid = 1'b0;
        low_cnt = 0;
        for (int j = 0; j < 200; j++) begin
            if (!if8.tx_ready) low_cnt++;
            if (j >= 8 && (j - 8) % 16 == 0 && (j - 8) / 16 < 10)
                check($sformatf("tx_a5_bit%0d", (j - 8) / 16), txd8, f_a5[(j - 8) / 16]);
            @(negedge clk);
        end
        check("tx_a5_ready_low_cycles", low_cnt, 160);
        check("tx_a5_ready_after", if8.tx_ready, 1);

        // ---- 8E2 loopback 0x3C ----
        ife.tx_data = 8'h3C; ife.tx_valid = 1'b1;
        @(negedge clk);
        ife.tx_valid = 1'b0;
        low_cnt = 0;
        for (int j = 0; j < 260; j++) begin
            if (!ife.tx_ready) low_cnt++;
            if (j >= 8 && (j - 8) % 16 == 0 && (j - 8) / 16 < 12)
                check($sformatf("tx_3c_bit%0d", (j - 8) / 16), txde, f_3c[(j - 8) / 16]);
            @(negedge clk);
        end
        check("tx_3c_ready_low_cycles", low_cnt, 192);
        check("lb_rx_valid", ife.rx_valid, 1);
        check("lb_rx_data", ife.rx_data, 8'h3C);
        check("lb_parity_err", ife.rx_parity_err, 0);
        check("lb_frame_err", ife.rx_frame_err, 0);
        ife.rx_ready = 1'b1; @(negedge clk); ife.rx_ready = 1'b0;
        check("lb_consumed", ife.rx_valid, 0);

        // ---- 8O1 RX: odd parity of 0x01 is 0, so a 1 in the parity slot is bad ----
        rx_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        cycles(4);
        check("odd_bad_rx_valid", ifo.rx_valid, 1);
        check("odd_bad_rx_data", ifo.rx_data, 8'h01);
        check("odd_bad_parity_err", ifo.rx_parity_err, 1);
        check("odd_bad_frame_err", ifo.rx_frame_err, 0);
        ifo.rx_ready = 1'b1; @(negedge clk); ifo.rx_ready = 1'b0;
        cycles(20);
        rx_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        cycles(4);
        check("odd_good_rx_valid", ifo.rx_valid, 1);
        check("odd_good_parity_err", ifo.rx_parity_err, 0);
        ifo.rx_ready = 1'b1; @(negedge clk); ifo.rx_ready = 1'b0;

        // ---- frame error then clean frame ----
        rx_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        cycles(4);
        check("ferr_rx_valid", if8.rx_valid, 1);
        check("ferr_rx_data", if8.rx_data, 8'h55);
        check("ferr_frame_err", if8.rx_frame_err, 1);
        check("ferr_parity_err", if8.rx_parity_err, 0);
        if8.rx_ready = 1'b1; @(negedge clk); if8.rx_ready = 1'b0;
        cycles(40);
        check("ferr_no_spurious", if8.rx_valid, 0);
        rx_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        cycles(4);
        check("clean_rx_valid", if8.rx_valid, 1);
        check("clean_rx_data", if8.rx_data, 8'h5A);
        check("clean_frame_err", if8.rx_frame_err, 0);
        if8.rx_ready = 1'b1; @(negedge clk); if8.rx_ready = 1'b0;
        cycles(20);

        // ---- glitch: 3-cycle low pulse is a false start ----
        rxd8 = 1'b0; cycles(3); rxd8 = 1'b1;
        cycles(60);
        check("glitch_rx_valid", if8.rx_valid, 0);

        // ---- overrun: second frame dropped, first kept ----
        ovr_base = ovr_cnt;
        rx_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        rx_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        cycles(4);
        check("ovr_rx_valid", if8.rx_valid, 1);
        check("ovr_rx_data", if8.rx_data, 8'h11);
        check("ovr_pulse_cycles", ovr_cnt - ovr_base, 1);
        if8.rx_ready = 1'b1; @(negedge clk); if8.rx_ready = 1'b0;
        check("ovr_consumed", if8.rx_valid, 0);
        cycles(20);

        // ---- reset in the middle of a TX frame (frame bit 4 is a low data bit) ----
        if8.tx_data = 8'h00; if8.tx_valid = 1'b1;
        @(negedge clk);
        if8.tx_valid = 1'b0;
        cycles(72);
        check("rstmid_txd_before", txd8, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_txd_high", txd8, 1);
        check("rstmid_tx_ready_in_rst", if8.tx_ready, 0);
        cycles(2);
        check("rstmid_tx_ready_hold", if8.tx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_tx_ready_after", if8.tx_ready, 1);
        low_cnt = 0;
        for (int j = 0; j < 200; j++) begin
            if (txd8 !== 1'b1) low_cnt++;
            @(negedge clk);
        end
        check("rstmid_no_resume", low_cnt, 0);

        // ---- reset in the middle of an RX frame ----
        rx_bit(1'b0, 1'b0);
        rx_bit(1'b0, 1'b0);
        rx_bit(1'b0, 1'b0);
        rx_bit(1'b0, 1'b0);
        rst = 1'b1; rxd8 = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(200);
        check("rx_rst_no_valid", if8.rx_valid, 0);
        check("rx_rst_no_overrun", ovr_cnt - ovr_base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
